// File: rtl/nd_intr_pkg.sv
// Shared types and constants for the NORD-10/S interrupt level control.
package nd_intr_pkg;

  localparam int LEV_W    = 4;
  localparam int NLEV     = 16;
  localparam int EXT_BASE = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    SETTLE = 2'd2
  } lvl_state_e;

endpackage

// File: rtl/intr_level_ctl_prio_enc16.sv
// 16-input priority encoder: index of the highest set bit plus a valid flag.
module prio_enc16
  import nd_intr_pkg::*;
(
  input  logic [NLEV-1:0]  i_vec,
  output logic [LEV_W-1:0] o_idx,
  output logic             o_valid
);

  always_comb begin
    o_idx = '0;
    for (int i = 0; i < NLEV; i++) begin
      if (i_vec[i]) o_idx = LEV_W'(i);
    end
  end

  assign o_valid = |i_vec;

endmodule

// File: rtl/intr_level_ctl.sv
// Interrupt level control: PIE/PID/PIL/IONI registers, level arbitration and
// the LVREQ/LVACK level-change handshake with the microsequencer.
module intr_level_ctl
  import nd_intr_pkg::*;
#(
  parameter int EXT_BASE_P  = EXT_BASE,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        MCL,
  input  logic [15:0] BUS,
  input  logic        PIE_WR,
  input  logic        PID_WR,
  input  logic        SWSET,
  input  logic [3:0]  SWLEV,
  input  logic [3:0]  EXTINT,
  input  logic        ION,
  input  logic        IOF,
  input  logic        PIL_WR,
  input  logic [3:0]  PIL_IN,
  input  logic        LVACK,
  output logic [3:0]  PIL,
  output logic [15:0] PIE,
  output logic [15:0] PID,
  output logic        IONI,
  output logic        LVREQ,
  output logic [3:0]  NEWLEV,
  output logic [1:0]  o_dbg_state
);

  // Handshake: LVREQ is held with NEWLEV stable until either LVACK is seen
  // (the level is taken, PIL<=NEWLEV) or the request is withdrawn by the
  // controller; LVACK is only meaningful in a cycle where LVREQ=1.

  lvl_state_e               r_state;
  logic [SYNC_STAGES-1:0][3:0] r_ext_sync;
  logic [3:0]               r_ext_prev;

  logic [3:0]  w_ext_rise;
  logic [15:0] w_set_mask;
  logic [15:0] w_pid_next;
  logic [15:0] w_pend;
  logic [3:0]  w_h;
  logic        w_hv;
  logic        w_fire;
  logic        w_withdraw;

  assign w_ext_rise = r_ext_sync[SYNC_STAGES-1] & ~r_ext_prev;
  assign w_set_mask = (SWSET ? (16'h0001 << SWLEV) : 16'h0000)
                    | (16'(w_ext_rise) << EXT_BASE_P);
  // A set always beats a simultaneous software clear.
  assign w_pid_next = (PID_WR ? BUS : PID) | w_set_mask;

  assign w_pend = PIE & PID;

  prio_enc16 u_prio (
    .i_vec   (w_pend),
    .o_idx   (w_h),
    .o_valid (w_hv)
  );

  assign w_fire     = IONI & w_hv & (w_h > PIL);
  assign w_withdraw = ~IONI | ~w_pend[NEWLEV] | (NEWLEV <= PIL);

  assign o_dbg_state = r_state;

  always_ff @(posedge clk or posedge MCL) begin
    if (MCL) begin
      r_ext_sync <= '0;
      r_ext_prev <= '0;
    end else begin
      r_ext_sync[0] <= EXTINT;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        r_ext_sync[s] <= r_ext_sync[s-1];
      end
      r_ext_prev <= r_ext_sync[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clk or posedge MCL) begin
    if (MCL) begin
      PIE  <= '0;
      PID  <= '0;
      IONI <= 1'b0;
    end else begin
      if (PIE_WR) PIE <= BUS;
      PID <= w_pid_next;
      if (IOF)      IONI <= 1'b0;
      else if (ION) IONI <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge MCL) begin
    if (MCL) begin
      r_state <= IDLE;
      PIL     <= '0;
      LVREQ   <= 1'b0;
      NEWLEV  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (PIL_WR) PIL <= PIL_IN;
          if (w_fire) begin
            r_state <= REQ;
            NEWLEV  <= w_h;
            LVREQ   <= 1'b1;
          end
        end
        REQ: begin
          if (LVACK) begin
            PIL     <= NEWLEV;
            LVREQ   <= 1'b0;
            r_state <= SETTLE;
          end else begin
            if (PIL_WR) PIL <= PIL_IN;
            if (w_withdraw) begin
              LVREQ   <= 1'b0;
              r_state <= IDLE;
            end
          end
        end
        // PIL held for one cycle so the downstream level latch sees it stable.
        SETTLE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          LVREQ   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_intr_level_ctl.sv
// Directed bench for intr_level_ctl: hand-computed register and handshake values.
module tb_intr_level_ctl;

  logic        clk;
  logic        MCL;
  logic [15:0] BUS;
  logic        PIE_WR, PID_WR, SWSET, ION, IOF, PIL_WR, LVACK;
  logic [3:0]  SWLEV, EXTINT, PIL_IN;
  logic [3:0]  PIL, NEWLEV;
  logic [15:0] PIE, PID;
  logic        IONI, LVREQ;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [1:0] S_IDLE = 2'd0, S_REQ = 2'd1, S_SETTLE = 2'd2;

  intr_level_ctl dut (
    .clk(clk), .MCL(MCL), .BUS(BUS), .PIE_WR(PIE_WR), .PID_WR(PID_WR),
    .SWSET(SWSET), .SWLEV(SWLEV), .EXTINT(EXTINT), .ION(ION), .IOF(IOF),
    .PIL_WR(PIL_WR), .PIL_IN(PIL_IN), .LVACK(LVACK), .PIL(PIL), .PIE(PIE),
    .PID(PID), .IONI(IONI), .LVREQ(LVREQ), .NEWLEV(NEWLEV),
    .o_dbg_state(dbg_state)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    BUS = '0; PIE_WR = 0; PID_WR = 0; SWSET = 0; SWLEV = '0;
    ION = 0; IOF = 0; PIL_WR = 0; PIL_IN = '0; LVACK = 0;
  endtask

  initial begin
    idle_inputs();
    EXTINT = '0;
    MCL = 1'b1;
    step(); step();
    chk("rst_pil", 16'(PIL), 16'h0);
    chk("rst_pie", PIE, 16'h0);
    chk("rst_pid", PID, 16'h0);
    chk("rst_ioni", 16'(IONI), 16'h0);
    chk("rst_lvreq", 16'(LVREQ), 16'h0);
    chk("rst_state", 16'(dbg_state), 16'(S_IDLE));
    MCL = 1'b0;
    step();

    // reset mid-REQ
    BUS = 16'h0400; PIE_WR = 1; PID_WR = 1; ION = 1;
    step();
    idle_inputs();
    chk("mr_pid", PID, 16'h0400);
    step();
    chk("mr_lvreq", 16'(LVREQ), 16'h1);
    chk("mr_newlev", 16'(NEWLEV), 16'd10);
    MCL = 1'b1;
    #1;
    chk("mr_async_lvreq", 16'(LVREQ), 16'h0);
    chk("mr_async_newlev", 16'(NEWLEV), 16'h0);
    chk("mr_async_pid", PID, 16'h0);
    chk("mr_async_ioni", 16'(IONI), 16'h0);
    step();
    MCL = 1'b0;
    step();
    chk("mr_pil", 16'(PIL), 16'h0);

    // basic level change to 13
    ION = 1; BUS = 16'h2000; PIE_WR = 1;
    step();
    idle_inputs();
    SWSET = 1; SWLEV = 4'd13;
    step();
    idle_inputs();
    chk("bc_pid", PID, 16'h2000);
    chk("bc_no_req_yet", 16'(LVREQ), 16'h0);
    step();
    chk("bc_lvreq", 16'(LVREQ), 16'h1);
    chk("bc_newlev", 16'(NEWLEV), 16'd13);
    chk("bc_state_req", 16'(dbg_state), 16'(S_REQ));
    LVACK = 1;
    step();
    LVACK = 0;
    chk("bc_pil", 16'(PIL), 16'd13);
    chk("bc_lvreq_low", 16'(LVREQ), 16'h0);
    chk("bc_settle", 16'(dbg_state), 16'(S_SETTLE));
    step();
    chk("bc_idle", 16'(dbg_state), 16'(S_IDLE));
    chk("bc_no_refire", 16'(LVREQ), 16'h0);

    // no fire at or below PIL
    PIL_WR = 1; PIL_IN = 4'd5;
    step();
    idle_inputs();
    chk("nf_pil", 16'(PIL), 16'd5);
    BUS = 16'h0030; PIE_WR = 1; PID_WR = 1;
    step();
    idle_inputs();
    step(); step();
    chk("nf_no_req", 16'(LVREQ), 16'h0);
    BUS = 16'h0070; PIE_WR = 1; SWSET = 1; SWLEV = 4'd6;
    step();
    idle_inputs();
    chk("nf_pid6", PID, 16'h0070);
    step();
    chk("nf_lvreq6", 16'(LVREQ), 16'h1);
    chk("nf_newlev6", 16'(NEWLEV), 16'd6);
    BUS = 16'h0000; PID_WR = 1;
    step();
    idle_inputs();
    step();
    chk("nf_clear_wd", 16'(LVREQ), 16'h0);

    // withdraw by PID clear, level 11
    BUS = 16'h0800; PIE_WR = 1; PID_WR = 1;
    step();
    idle_inputs();
    step();
    chk("wd_lvreq", 16'(LVREQ), 16'h1);
    chk("wd_newlev", 16'(NEWLEV), 16'd11);
    BUS = 16'h0000; PID_WR = 1;
    step();
    idle_inputs();
    chk("wd_still_req", 16'(LVREQ), 16'h1);
    step();
    chk("wd_lvreq_low", 16'(LVREQ), 16'h0);
    chk("wd_pil", 16'(PIL), 16'd5);

    // withdraw by IOF
    BUS = 16'h0800; PID_WR = 1;
    step();
    idle_inputs();
    step();
    chk("wi_lvreq", 16'(LVREQ), 16'h1);
    IOF = 1;
    step();
    idle_inputs();
    chk("wi_ioni", 16'(IONI), 16'h0);
    step();
    chk("wi_lvreq_low", 16'(LVREQ), 16'h0);
    chk("wi_pil", 16'(PIL), 16'd5);

    // ION and IOF together
    BUS = 16'h0000; PID_WR = 1;
    step();
    idle_inputs();
    ION = 1;
    step();
    chk("io_on", 16'(IONI), 16'h1);
    IOF = 1;
    step();
    idle_inputs();
    chk("io_both_off", 16'(IONI), 16'h0);

    // EXTINT[2] edge lands with a PID write-clear
    BUS = 16'h0003; PID_WR = 1;
    step();
    idle_inputs();
    chk("ex_pre", PID, 16'h0003);
    EXTINT = 4'b0100;
    step(); step();
    BUS = 16'h0000; PID_WR = 1;
    step();
    idle_inputs();
    chk("ex_set_wins", PID, 16'h1000);
    EXTINT = 4'b0000;

    // LVACK beats PIL_WR
    ION = 1; BUS = 16'h1000; PIE_WR = 1;
    step();
    idle_inputs();
    step();
    chk("ak_lvreq", 16'(LVREQ), 16'h1);
    chk("ak_newlev", 16'(NEWLEV), 16'd12);
    LVACK = 1; PIL_WR = 1; PIL_IN = 4'd3;
    step();
    idle_inputs();
    chk("ak_pil", 16'(PIL), 16'd12);
    chk("ak_lvreq_low", 16'(LVREQ), 16'h0);
    PIL_WR = 1; PIL_IN = 4'd3;
    step();
    idle_inputs();
    chk("ak_settle_ignores_pilwr", 16'(PIL), 16'd12);

    // EXTINT[0] held high across a clear of PID[10]
    EXTINT = 4'b0001;
    step(); step(); step();
    chk("eh_set", PID, 16'h1400);
    BUS = 16'h1000; PID_WR = 1;
    step();
    idle_inputs();
    step(); step(); step();
    chk("eh_held_stays_clear", PID, 16'h1000);
    EXTINT = 4'b0000;
    step(); step(); step();
    EXTINT = 4'b0001;
    step(); step();
    chk("eh_not_yet", PID, 16'h1000);
    step();
    chk("eh_new_edge", PID, 16'h1400);
    EXTINT = 4'b0000;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/intr_level_ctl.md
Name: intr_level_ctl

Overview:
- Interrupt level control for the NORD-10/S CPU.
- Holds the PIE (enable) and PID (detect) registers, the current program level PIL, and the interrupt-system-on flag IONI.
- Arbitrates the highest pending enabled level and runs a request/acknowledge handshake with the microsequencer to change level.
- PIL feeds the level mux in the OR logic stage directly downstream.

Parameters:
- EXT_BASE, 10, PID bit index driven by EXTINT[0]; EXTINT[i] maps to PID[EXT_BASE+i].
- SYNC_STAGES, 2, synchroniser depth for EXTINT.

Ports:
- clk  in  1  system clock
- MCL  in  1  master clear; asynchronous, active-high reset
- BUS  in  16  data for PIE/PID writes
- PIE_WR  in  1  load PIE from BUS
- PID_WR  in  1  load PID from BUS
- SWSET  in  1  microcode set of PID[SWLEV]
- SWLEV  in  4  level for SWSET
- EXTINT  in  4  asynchronous external requests, levels 10-13
- ION  in  1  turn interrupt system on
- IOF  in  1  turn interrupt system off
- PIL_WR  in  1  load PIL from PIL_IN (level return / WAIT)
- PIL_IN  in  4  new PIL for PIL_WR
- LVACK  in  1  microsequencer accepts the pending level change
- PIL  out  4  current program level
- PIE  out  16  enable register
- PID  out  16  detect register
- IONI  out  1  interrupt system on
- LVREQ  out  1  level change requested
- NEWLEV  out  4  target level, valid while LVREQ=1

Behaviour:
- Reset (MCL high, async): PIL=0, PIE=0, PID=0, IONI=0, LVREQ=0, NEWLEV=0, state=IDLE. MCL asserted mid-handshake aborts it; no PIL update occurs.
- All outputs are registered.
- PID next value = (PID_WR ? BUS : PID) | set-mask. The set-mask ORs in SWSET at SWLEV and the EXTINT edges, so a set wins over a simultaneous write-clear.
- EXTINT path: SYNC_STAGES-flop synchroniser, then rising-edge detect. Each edge sets its PID bit once. A held-high input does not re-set the bit after software clears it.
- IONI: ION sets it, IOF clears it; IOF wins if both are asserted.
- PIE_WR loads PIE from BUS on the next edge.
- Arbitration (combinational): pend = PIE & PID; h = index of highest set bit of pend; hv = pend!=0.
- fire = IONI & hv & (h > PIL). Level 0 can never fire.
- State IDLE:
  - PIL_WR loads PIL.
  - If fire: next state REQ, NEWLEV<=h, LVREQ<=1. LVREQ therefore appears 1 cycle after the enabling write.
- State REQ:
  - NEWLEV is frozen.
  - LVACK: PIL<=NEWLEV, LVREQ<=0, next state SETTLE.
  - Otherwise, withdraw (LVREQ<=0, next state IDLE) if IONI=0, or pend[NEWLEV]=0, or NEWLEV<=PIL.
  - LVACK has priority over withdraw and over PIL_WR in the same cycle.
  - PIL_WR without LVACK loads PIL, then the withdraw check applies next cycle.
  - A higher level becoming pending while in REQ does not retarget the request. It fires after SETTLE.
- State SETTLE: one cycle, PIL stable for the downstream MIR level latch. PIL_WR is ignored. Next state IDLE.
- PID bits are not auto-cleared on level change. Microcode clears them via PID_WR.

Decomposition:
- Package nd_intr_pkg holds:
  - the state enum (IDLE, REQ, SETTLE);
  - LEV_W=4, NLEV=16;
  - EXT_BASE default.
- Sub-module prio_enc16: 16-bit input; outputs 4-bit index of the highest set bit plus a valid flag. Purely combinational; reused by the IDENT logic.

Test Plan:
- Reset mid-REQ: PIE=16'h0400, PID_WR 16'h0400, ION, then assert MCL while LVREQ=1 -> all outputs 0, PIL stays 0.
- Basic change: ION; PIE=16'h2000; SWSET at SWLEV=13 -> LVREQ=1, NEWLEV=13 next cycle; LVACK -> PIL=13 on the following edge, LVREQ=0, one SETTLE cycle.
- No fire at or below PIL: PIL_WR 5; PIE=PID=16'h0030 (levels 4,5) -> LVREQ stays 0. Then SWSET level 6 with PIE bit 6 set -> NEWLEV=6.
- Withdraw: in REQ for level 11, PID_WR 16'h0000 with no LVACK -> LVREQ=0 next cycle, PIL unchanged. Repeat with IOF -> same result.
- Simultaneous events: PID_WR 16'h0000 in the same cycle as an EXTINT[2] edge -> PID=16'h1000. ION and IOF together -> IONI=0. LVACK with PIL_WR 3 -> PIL=NEWLEV.
- EXTINT held high across a software clear of PID[10] -> bit stays 0. A new edge after deassert -> bit sets.
